// File: rtl/return_array_pkg.sv
// Shared types and the combinational result-array function for return_array_function.
package return_array_pkg;

   localparam int RES_W = 8;
   localparam int RES_N = 4;

   typedef logic [RES_W-1:0] result_arr_t [RES_N];

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_SHL  = 2'b01,
      OP_BIT  = 2'b10,
      OP_MISC = 2'b11
   } op_e;

   localparam logic [RES_W-1:0] MASK_HI  = 8'hF0;
   localparam logic [RES_W-1:0] MASK_LO  = 8'h0F;
   localparam logic [RES_W-1:0] MASK_ALL = 8'hFF;
   localparam logic [RES_W-1:0] MOD_BASE = 8'd10;

   // All results wrap naturally at RES_W bits; nothing saturates.
   function automatic result_arr_t compute_results(input logic [RES_W-1:0] d, input op_e op);
      result_arr_t res;
      res = '{default: '0};
      case (op)
         OP_INC: begin
            for (int k = 0; k < RES_N; k++) res[k] = d + RES_W'(k + 1);
         end
         OP_SHL: begin
            for (int k = 0; k < RES_N; k++) res[k] = d << (k + 1);
         end
         OP_BIT: begin
            res[0] = ~d;
            res[1] = d & MASK_HI;
            res[2] = d | MASK_LO;
            res[3] = d ^ MASK_ALL;
         end
         OP_MISC: begin
            res[0] = d;
            res[1] = d << 1;
            res[2] = d >> 1;
            res[3] = d % MOD_BASE;
         end
         default: res = '{default: '0};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/return_array_function.sv
// Registers a four-element result array computed from one operand per accepted cycle.
// Optional macro RETURN_ARRAY_CLEAR_IDLE_EN clears the array on idle cycles instead of holding it.
module return_array_function
   import return_array_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_RES  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   input  logic [1:0]        op_select,
   output logic [DATA_W-1:0] result_array [N_RES],
   output logic              result_valid
);

   result_arr_t result_q, result_d;
   logic        valid_q, valid_d;

   always_comb begin
      valid_d  = data_valid;
      result_d = result_q;
      if (data_valid) begin
         result_d = compute_results(data_in, op_e'(op_select));
      end
`ifdef RETURN_ARRAY_CLEAR_IDLE_EN
      else begin
         result_d = '{default: '0};
      end
`endif
   end

   // NOTE: the result array is reset too, because it is a visible output that must read 00 during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '{default: '0};
         valid_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result_array = result_q;
   assign result_valid = valid_q;

endmodule

// File: tb/tb_return_array_function.sv
// Self-checking bench for return_array_function: directed vectors, random traffic, reset cases.
module tb_return_array_function;

   logic       clk;
   logic       rst_n;
   logic [7:0] data_in;
   logic       data_valid;
   logic [1:0] op_select;
   logic [7:0] result_array [4];
   logic       result_valid;

   int n_checks = 0;
   int n_fail   = 0;

   return_array_function #(.DATA_W(8), .N_RES(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .op_select    (op_select),
      .result_array (result_array),
      .result_valid (result_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model straight from the arithmetic rules, packed element 0 in the top byte.
   function automatic logic [31:0] model(input int d, input int op);
      int e[4];
      case (op)
         0: e = '{(d + 1) % 256, (d + 2) % 256, (d + 3) % 256, (d + 4) % 256};
         1: e = '{(d * 2) % 256, (d * 4) % 256, (d * 8) % 256, (d * 16) % 256};
         2: e = '{255 - d, d & 240, d | 15, d ^ 255};
         default: e = '{d, (d * 2) % 256, d / 2, d % 10};
      endcase
      return {8'(e[0]), 8'(e[1]), 8'(e[2]), 8'(e[3])};
   endfunction

   function automatic logic [31:0] dut_arr();
      return {result_array[0], result_array[1], result_array[2], result_array[3]};
   endfunction

   task automatic drive(input logic [7:0] d, input logic [1:0] op, input logic v);
      @(negedge clk);
      data_in    = d;
      op_select  = op;
      data_valid = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      data_valid = 1'b1;
      data_in = 8'h77;
      op_select = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_immediate: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_valid_ignored: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
      @(negedge clk);
      data_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_release: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
   endtask

   task automatic test_directed();
      logic [7:0]  dv [6] = '{8'h0A, 8'h05, 8'h90, 8'hA5, 8'h14, 8'hFE};
      logic [1:0]  ov [6] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
      logic [31:0] ev [6] = '{32'h0B0C0D0E, 32'h0A142850, 32'h20408000,
                              32'h5AA0AF5A, 32'h14280A00, 32'hFF000102};
      for (int i = 0; i < 6; i++) begin
         drive(dv[i], ov[i], 1'b1);
         @(posedge clk);
         #1;
         n_checks++;
         if (result_valid !== 1'b1 || dut_arr() !== ev[i]) begin
            n_fail++;
            $display("FAIL directed_%0d: valid=%b arr=%h, want valid=1 arr=%h", i, result_valid, dut_arr(), ev[i]);
         end
         drive(8'h00, 2'b00, 1'b0);
         @(posedge clk);
         #1;
         n_checks++;
         if (result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_pulse_%0d: valid=%b, want 0", i, result_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive(8'h32, 2'b00, 1'b1);
      @(posedge clk);
      #1;
      n_checks++;
      if (result_valid !== 1'b1 || dut_arr() !== 32'h33343536) begin
         n_fail++;
         $display("FAIL b2b_first: valid=%b arr=%h, want valid=1 arr=33343536", result_valid, dut_arr());
      end
      drive(8'h33, 2'b00, 1'b1);
      @(posedge clk);
      #1;
      n_checks++;
      if (result_valid !== 1'b1 || dut_arr() !== 32'h34353637) begin
         n_fail++;
         $display("FAIL b2b_second: valid=%b arr=%h, want valid=1 arr=34353637", result_valid, dut_arr());
      end
      drive(8'h00, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      n_checks++;
`ifdef RETURN_ARRAY_CLEAR_IDLE_EN
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_after_b2b: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
`else
      if (result_valid !== 1'b0 || dut_arr() !== 32'h34353637) begin
         n_fail++;
         $display("FAIL idle_after_b2b: valid=%b arr=%h, want valid=0 arr=34353637", result_valid, dut_arr());
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] exp_arr;
      logic        exp_v;
      logic [7:0]  d;
      logic [1:0]  op;
      logic        v;
      exp_arr = dut_arr();
      for (int i = 0; i < 200; i++) begin
         d  = 8'($urandom_range(0, 255));
         op = 2'($urandom_range(0, 3));
         v  = ($urandom_range(0, 3) != 0);
         drive(d, op, v);
         exp_v = v;
         if (v) exp_arr = model(int'(d), int'(op));
`ifdef RETURN_ARRAY_CLEAR_IDLE_EN
         else exp_arr = 32'h0;
`endif
         @(posedge clk);
         #1;
         n_checks++;
         if (result_valid !== exp_v || dut_arr() !== exp_arr) begin
            n_fail++;
            $display("FAIL random_%0d d=%h op=%0d v=%b: valid=%b arr=%h, want valid=%b arr=%h",
                     i, d, op, v, result_valid, dut_arr(), exp_v, exp_arr);
         end
      end
   endtask

   task automatic test_reset_midflight();
      drive(8'h21, 2'b10, 1'b1);
      @(posedge clk);
      @(negedge clk);
      data_in = 8'h64;
      op_select = 2'b11;
      data_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL midflight_immediate: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
      #9;
      rst_n = 1'b1;
      data_valid = 1'b0;
      n_checks++;
      if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
         n_fail++;
         $display("FAIL midflight_held: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (result_valid !== 1'b0 || dut_arr() !== 32'h0) begin
            n_fail++;
            $display("FAIL midflight_after: valid=%b arr=%h, want valid=0 arr=00000000", result_valid, dut_arr());
         end
      end
      drive(8'h64, 2'b11, 1'b1);
      @(posedge clk);
      #1;
      n_checks++;
      if (result_valid !== 1'b1 || dut_arr() !== 32'h64C83200) begin
         n_fail++;
         $display("FAIL midflight_resume: valid=%b arr=%h, want valid=1 arr=64c83200", result_valid, dut_arr());
      end
   endtask

   initial begin
      data_in = 8'h00;
      op_select = 2'b00;
      data_valid = 1'b0;
      rst_n = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
